i2c_write3_master: RTL and testbench

//  Open-drain I2C write master for the audio-codec config path; consumes {SLAVE_ADDR,SUB_ADDR,DATA} from the config sequencer.

---
 rtl/i2c_write3_master.sv | 180 ++++++++++++++++++
 tb/tb_i2c_write3_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_write3_master.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_write3_master
//  Purpose  : Open-drain I2C write master. Sends START, three bytes
//             {slave addr+W, sub-addr, data} MSB-first each followed by an
//             ACK slot, then STOP. Timing is derived from a quarter-bit tick
//             on the system clock; there is no derived clock domain.
//  Revision : 1.0  initial release
// ============================================================================
module i2c_write3_master #(
  parameter int CLK_Freq = 53000000,
  parameter int I2C_Freq = 100000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        oI2C_SCLK,
  inout  wire         ioI2C_SDAT
);

  // Quarter-bit period in system clocks (must be at least 1).
  localparam int          c_DIV       = CLK_Freq / (4 * I2C_Freq);
  localparam logic [15:0] c_TICK_LAST = 16'(c_DIV - 1);
  localparam logic [4:0]  c_LAST_SLOT = 5'd26;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BIT   = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_tickCnt;
  logic [1:0]  r_phase;    // tick index inside START/STOP or quarter inside a slot
  logic [4:0]  r_slot;     // 0..26, slots 8/17/26 are ACK slots
  logic [23:0] r_shift;    // outgoing bits, MSB is the next data bit
  logic        r_accum;    // 1 once any ACK slot saw SDA high
  logic        r_sdaLow;   // 1 pulls SDA low, 0 releases it

  logic w_running;
  logic w_tick;
  logic w_ackSlot;
  logic w_sdaIn;

  assign w_running  = (r_state == S_START) || (r_state == S_BIT) || (r_state == S_STOP);
  assign w_tick     = w_running && (r_tickCnt == c_TICK_LAST);
  assign w_ackSlot  = (r_slot == 5'd8) || (r_slot == 5'd17) || (r_slot == 5'd26);
  assign w_sdaIn    = ioI2C_SDAT;
  assign ioI2C_SDAT = r_sdaLow ? 1'b0 : 1'bz;

  // Quarter-bit tick divider; held at zero whenever the bus is not active.
  always_ff @(posedge iCLK) begin
    if (iRST || !w_running || w_tick) begin
      r_tickCnt <= '0;
    end else begin
      r_tickCnt <= r_tickCnt + 16'd1;
    end
  end

  // Transfer sequencer: bus phases advance only on ticks, outputs are registered.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_phase   <= 2'd0;
      r_slot    <= 5'd0;
      r_shift   <= '0;
      r_accum   <= 1'b0;
      r_sdaLow  <= 1'b0;
      oI2C_SCLK <= 1'b1;
      oEND      <= 1'b0;
      oACK      <= 1'b0;
      oBUSY     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iGO) begin
            r_shift <= iDATA;
            r_accum <= 1'b0;
            r_phase <= 2'd0;
            oBUSY   <= 1'b1;
            r_state <= S_START;
          end
        end

        S_START: begin
          if (w_tick) begin
            case (r_phase)
              2'd0: begin
                r_sdaLow  <= 1'b0;
                oI2C_SCLK <= 1'b1;
                r_phase   <= 2'd1;
              end
              2'd1: begin
                r_sdaLow <= 1'b1;          // START: SDA falls while SCL high
                r_phase  <= 2'd2;
              end
              default: begin
                oI2C_SCLK <= 1'b0;
                r_slot    <= 5'd0;
                r_phase   <= 2'd0;
                r_state   <= S_BIT;
              end
            endcase
          end
        end

        S_BIT: begin
          if (w_tick) begin
            r_phase <= r_phase + 2'd1;
            case (r_phase)
              2'd0: begin
                oI2C_SCLK <= 1'b0;
                r_sdaLow  <= w_ackSlot ? 1'b0 : ~r_shift[23];
              end
              2'd1: oI2C_SCLK <= 1'b1;
              2'd2: begin
                if (w_ackSlot) begin
                  r_accum <= r_accum | w_sdaIn;
                end
              end
              default: begin
                oI2C_SCLK <= 1'b0;
                if (!w_ackSlot) begin
                  r_shift <= {r_shift[22:0], 1'b0};
                end
                if (r_slot == c_LAST_SLOT) begin
                  r_state <= S_STOP;
                end else begin
                  r_slot <= r_slot + 5'd1;
                end
              end
            endcase
          end
        end

        S_STOP: begin
          if (w_tick) begin
            case (r_phase)
              2'd0: begin
                oI2C_SCLK <= 1'b0;
                r_sdaLow  <= 1'b1;
                r_phase   <= 2'd1;
              end
              2'd1: begin
                oI2C_SCLK <= 1'b1;
                r_phase   <= 2'd2;
              end
              default: begin
                r_sdaLow <= 1'b0;          // STOP: SDA rises while SCL high
                r_phase  <= 2'd0;
                oEND     <= 1'b1;
                oACK     <= r_accum;
                oBUSY    <= 1'b0;
                r_state  <= S_DONE;
              end
            endcase
          end
        end

        S_DONE: begin
          // A new transfer needs iGO to drop first.
          if (!iGO) begin
            oEND    <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_write3_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_write3_master
//  Purpose  : Self-checking bench for i2c_write3_master with an ACKing slave
//             model, SDA pull-up and a bus monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_write3_master;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [23:0] iDATA;
  logic        iGO;
  logic        oEND;
  logic        oACK;
  logic        oBUSY;
  logic        oI2C_SCLK;
  wire         ioI2C_SDAT;

  logic        slaveDrv = 1'b0;
  logic [2:0]  ackEn = 3'b000;       // bit b: slave ACKs byte b
  bit          slavePresent = 1'b0;

  int          riseCnt = 27;
  logic [26:0] capBits = '0;
  int          startCnt = 0;
  int          stopCnt = 0;

  int checks = 0;
  int failures = 0;

  pullup (ioI2C_SDAT);
  assign ioI2C_SDAT = slaveDrv ? 1'b0 : 1'bz;

  always #5 iCLK = ~iCLK;

  i2c_write3_master #(
    .CLK_Freq (800000),
    .I2C_Freq (100000)
  ) dut (
    .iCLK       (iCLK),
    .iRST       (iRST),
    .iDATA      (iDATA),
    .iGO        (iGO),
    .oEND       (oEND),
    .oACK       (oACK),
    .oBUSY      (oBUSY),
    .oI2C_SCLK  (oI2C_SCLK),
    .ioI2C_SDAT (ioI2C_SDAT)
  );

  // SDA edges while SCL is high are START (fall) or STOP (rise) conditions.
  always @(negedge ioI2C_SDAT) if (oI2C_SCLK === 1'b1) begin startCnt++; riseCnt = 0; end
  always @(posedge ioI2C_SDAT) if (oI2C_SCLK === 1'b1) stopCnt++;

  // Capture the bus bit on every rising SCL.
  always @(posedge oI2C_SCLK) begin
    if (riseCnt < 27) capBits[26 - riseCnt] = (ioI2C_SDAT !== 1'b0);
    riseCnt++;
  end

  // Slave: pull SDA low for the ACK slot that follows each 8 data bits.
  always @(negedge oI2C_SCLK) begin
    if (slavePresent && (riseCnt == 8 || riseCnt == 17 || riseCnt == 26) && ackEn[riseCnt / 9])
      slaveDrv = 1'b1;
    else
      slaveDrv = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transfer, checked against the bit sequence the protocol dictates.
  task automatic runXfer(input logic [23:0] data, input logic [2:0] acks, input bit present,
                         input bit midChange);
    logic [26:0] expBits;
    bit          expNack;
    bit          done;
    int          lat;
    expNack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      for (int k = 0; k < 8; k++) expBits[26 - (9 * b + k)] = data[23 - 8 * b - k];
      expBits[26 - (9 * b + 8)] = !(present && acks[b]);
      expNack = expNack | !(present && acks[b]);
    end
    ackEn        = acks;
    slavePresent = present;
    startCnt     = 0;
    stopCnt      = 0;
    iDATA        = data;
    iGO          = 1'b1;
    done         = 1'b0;
    lat          = 0;
    for (int cyc = 1; cyc <= 400 && !done; cyc++) begin
      @(negedge iCLK);
      if (cyc == 1) check("busyAccept", {31'd0, oBUSY}, 32'd1);
      if (midChange && cyc == 60) begin iDATA = ~data; iGO = 1'b0; end
      if (midChange && cyc == 64) iGO = 1'b1;
      if (oEND === 1'b1) begin done = 1'b1; lat = cyc - 1; end
    end
    if (!done) begin
      check("endTimeout", 32'd0, 32'd1);
    end else begin
      check("endLatency", (lat >= 227 && lat <= 229) ? 32'd228 : lat, 32'd228);
      check("ackStatus", {31'd0, oACK}, {31'd0, expNack});
      check("busyDone", {31'd0, oBUSY}, 32'd0);
      check("busBits", {5'd0, capBits}, {5'd0, expBits});
      check("sclRises", riseCnt, 32'd28);
      check("startCount", startCnt, 32'd1);
      check("stopCount", stopCnt, 32'd1);
      // iGO held high: stay in DONE, no restart.
      repeat (20) @(negedge iCLK);
      check("holdEnd", {31'd0, oEND}, 32'd1);
      check("holdNoStart", startCnt, 32'd1);
      iGO = 1'b0;
      @(negedge iCLK);
      check("endDrop", {31'd0, oEND}, 32'd0);
      check("ackRetain", {31'd0, oACK}, {31'd0, expNack});
      repeat (3) @(negedge iCLK);
    end
  endtask

  initial begin
    iRST  = 1'b1;
    iGO   = 1'b0;
    iDATA = '0;
    repeat (3) @(negedge iCLK);
    check("rstScl", {31'd0, oI2C_SCLK}, 32'd1);
    check("rstSda", {31'd0, ioI2C_SDAT !== 1'b0}, 32'd1);
    check("rstEnd", {31'd0, oEND}, 32'd0);
    check("rstAck", {31'd0, oACK}, 32'd0);
    check("rstBusy", {31'd0, oBUSY}, 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    runXfer(24'h340017, 3'b111, 1'b1, 1'b0);   // all acked
    runXfer(24'h340017, 3'b011, 1'b1, 1'b0);   // data byte NACKed
    runXfer(24'h340017, 3'b111, 1'b0, 1'b0);   // no slave
    runXfer(24'h340017, 3'b111, 1'b1, 1'b0);   // accumulator cleared
    runXfer(24'hA55A3C, 3'b111, 1'b1, 1'b1);   // iDATA/iGO disturbed mid-transfer

    // Reset in the middle of slot 12 while SCL is high.
    iDATA = 24'h12F0C3;
    ackEn = 3'b111;
    slavePresent = 1'b1;
    iGO = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 400 && !hit; c++) begin
        @(negedge iCLK);
        if (riseCnt == 13 && oI2C_SCLK === 1'b1) hit = 1'b1;
      end
      check("rstMidReach", {31'd0, hit}, 32'd1);
    end
    iRST = 1'b1;
    iGO  = 1'b0;
    @(negedge iCLK);
    check("midRstScl", {31'd0, oI2C_SCLK}, 32'd1);
    check("midRstSda", {31'd0, ioI2C_SDAT !== 1'b0}, 32'd1);
    check("midRstBusy", {31'd0, oBUSY}, 32'd0);
    check("midRstEnd", {31'd0, oEND}, 32'd0);
    iRST = 1'b0;
    repeat (5) @(negedge iCLK);
    runXfer(24'h12F0C3, 3'b111, 1'b1, 1'b0);

    // Randomised transfers.
    for (int n = 0; n < 6; n++) begin
      logic [23:0] d;
      logic [2:0]  a;
      d = 24'($urandom);
      a = 3'($urandom_range(0, 7));
      runXfer(d, a, ($urandom_range(0, 3) != 0), n[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
